// File: rtl/sprite_tile_rom.sv
// Fixed 12x12 sprite store for the snake renderer: head, body and apple tiles
// read in parallel from one tile-local address, one clock of latency.
module sprite_tile_rom (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] address,
  output logic [7:0] q_head,
  output logic [7:0] q_body,
  output logic [7:0] q_apple
);

  localparam logic [7:0] TILE_ENTRIES = 8'd144;
  localparam logic [7:0] PIX_BG       = 8'd0;
  localparam logic [7:0] PIX_EYE      = 8'd1;
  localparam logic [7:0] PIX_DARK     = 8'd2;
  localparam logic [7:0] PIX_GREEN    = 8'd3;
  localparam logic [7:0] PIX_STEM     = 8'd4;
  localparam logic [7:0] PIX_RED      = 8'd92;

  logic [7:0]         w_row;
  logic [7:0]         w_col;
  logic               w_in_range;
  logic               w_border;
  logic               w_eye;
  logic               w_stem;
  logic               w_in_disc;
  logic signed [8:0]  w_dr;
  logic signed [8:0]  w_dc;
  logic signed [17:0] w_dr_sq;
  logic signed [17:0] w_dc_sq;
  logic [7:0]         w_head;
  logic [7:0]         w_body;
  logic [7:0]         w_apple;

  logic [7:0]         r_q_head;
  logic [7:0]         r_q_body;
  logic [7:0]         r_q_apple;

  assign w_row      = address / 8'd12;
  assign w_col      = address % 8'd12;
  assign w_in_range = (address < TILE_ENTRIES);

  assign w_border = (w_row == 8'd0) || (w_row == 8'd11) ||
                    (w_col == 8'd0) || (w_col == 8'd11);
  assign w_eye    = (w_row == 8'd3) && ((w_col == 8'd3) || (w_col == 8'd8));
  assign w_stem   = (w_col == 8'd6) && (w_row <= 8'd1);

  // Doubled coordinates centre the disc on the pixel grid without fractions.
  assign w_dr      = $signed({w_row, 1'b0}) - 9'sd11;
  assign w_dc      = $signed({w_col, 1'b0}) - 9'sd11;
  assign w_dr_sq   = w_dr * w_dr;
  assign w_dc_sq   = w_dc * w_dc;
  assign w_in_disc = ((w_dr_sq + w_dc_sq) <= 18'sd121);

  always_comb begin
    w_body  = PIX_BG;
    w_head  = PIX_BG;
    w_apple = PIX_BG;
    if (w_in_range) begin
      w_body = w_border ? PIX_DARK : PIX_GREEN;
      w_head = w_eye ? PIX_EYE : w_body;
      if (w_stem)
        w_apple = PIX_STEM;
      else if (w_in_disc)
        w_apple = PIX_RED;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q_head  <= 8'd0;
      r_q_body  <= 8'd0;
      r_q_apple <= 8'd0;
    end else begin
      r_q_head  <= w_head;
      r_q_body  <= w_body;
      r_q_apple <= w_apple;
    end
  end

  assign q_head  = r_q_head;
  assign q_body  = r_q_body;
  assign q_apple = r_q_apple;

endmodule

// File: tb/tb_sprite_tile_rom.sv
// Directed checks of the sprite ROM plus a full-tile sweep against the tile rules.
module tb_sprite_tile_rom;

  logic       clock;
  logic       reset;
  logic [7:0] address;
  logic [7:0] q_head;
  logic [7:0] q_body;
  logic [7:0] q_apple;

  int n_checks;
  int n_fail;

  sprite_tile_rom dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .q_head  (q_head),
    .q_body  (q_body),
    .q_apple (q_apple)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive an address, let one edge pass, then check all three outputs.
  task automatic read3(input logic [7:0] a, input string tag,
                       input logic [7:0] e_head, input logic [7:0] e_body,
                       input logic [7:0] e_apple);
    address = a;
    @(posedge clock);
    #1;
    $display("txn %s addr=%0d head=%0d body=%0d apple=%0d", tag, a, q_head, q_body, q_apple);
    check({tag, ".head"},  q_head,  e_head);
    check({tag, ".body"},  q_body,  e_body);
    check({tag, ".apple"}, q_apple, e_apple);
  endtask

  // Tile rules expressed per (row, col).
  function automatic logic [7:0] m_body(input int r, input int c);
    return (r == 0 || r == 11 || c == 0 || c == 11) ? 8'd2 : 8'd3;
  endfunction

  function automatic logic [7:0] m_head(input int r, input int c);
    if (r == 3 && (c == 3 || c == 8)) return 8'd1;
    return m_body(r, c);
  endfunction

  function automatic logic [7:0] m_apple(input int r, input int c);
    int dx;
    int dy;
    if (c == 6 && r <= 1) return 8'd4;
    dy = 2 * r - 11;
    dx = 2 * c - 11;
    if (dx * dx + dy * dy <= 121) return 8'd92;
    return 8'd0;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    address  = 8'd66;

    // Reset held two edges: outputs stay cleared even with a valid address.
    @(posedge clock); #1;
    check("rst1.head", q_head, 8'd0);
    check("rst1.body", q_body, 8'd0);
    check("rst1.apple", q_apple, 8'd0);
    @(posedge clock); #1;
    check("rst2.head", q_head, 8'd0);
    check("rst2.body", q_body, 8'd0);
    check("rst2.apple", q_apple, 8'd0);
    reset = 1'b0;
    read3(8'd66,  "post_rst", 8'd3, 8'd3, 8'd92);

    // Corners, stem, eyes, interior.
    read3(8'd0,   "a0",   8'd2, 8'd2, 8'd0);
    read3(8'd143, "a143", 8'd2, 8'd2, 8'd0);
    read3(8'd132, "a132", 8'd2, 8'd2, 8'd0);
    read3(8'd6,   "a6",   8'd2, 8'd2, 8'd4);
    read3(8'd18,  "a18",  8'd3, 8'd3, 8'd4);
    read3(8'd39,  "a39",  8'd1, 8'd3, 8'd92);
    read3(8'd44,  "a44",  8'd1, 8'd3, 8'd92);
    // r1,c1: (-9)^2 + (-9)^2 = 162 > 121, so outside the apple disc.
    read3(8'd13,  "a13",  8'd3, 8'd3, 8'd0);
    read3(8'd12,  "a12",  8'd2, 8'd2, 8'd0);
    // r2,c4: 49 + 9 = 58, inside the disc.
    read3(8'd28,  "a28",  8'd3, 8'd3, 8'd92);

    // Out of range.
    read3(8'd144, "a144", 8'd0, 8'd0, 8'd0);
    read3(8'd255, "a255", 8'd0, 8'd0, 8'd0);

    // Mid-stream reset discards the pending read.
    address = 8'd39;
    reset   = 1'b1;
    @(posedge clock); #1;
    check("midrst.head", q_head, 8'd0);
    check("midrst.body", q_body, 8'd0);
    check("midrst.apple", q_apple, 8'd0);
    reset = 1'b0;
    read3(8'd39, "after_midrst", 8'd1, 8'd3, 8'd92);

    // Streaming sweep; the address moves mid-cycle and the outputs must hold.
    address = 8'd0;
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 12; c++) begin
        @(posedge clock); #1;
        check("sweep.head",  q_head,  m_head(r, c));
        check("sweep.body",  q_body,  m_body(r, c));
        check("sweep.apple", q_apple, m_apple(r, c));
        #1;
        address = 8'(12 * r + c + 1);
        #5;
        check("hold.head",  q_head,  m_head(r, c));
        check("hold.body",  q_body,  m_body(r, c));
        check("hold.apple", q_apple, m_apple(r, c));
      end
    end
    // The sweep ends by presenting 144, which reads as all zeros.
    @(posedge clock); #1;
    check("sweep_end.apple", q_apple, 8'd0);
    check("sweep_end.body",  q_body,  8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
